lum_stream_gen: RTL and testbench

LUM_STREAM_GEN -- requirements
Module: lum_stream_gen

---
 rtl/lum_stream_gen.sv | 139 +++++++++++++
 tb/tb_lum_stream_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lum_stream_gen.sv
// Luminance test-pattern generator with VGA-style raster timing.
// One pixel is emitted per pix_en strobe; all outputs are registered and
// lag the raster counters by one strobe. A pause request is honoured only
// at the frame boundary, where the generator parks in HOLD at (0,0).
module lum_stream_gen #(
    parameter int PIXEL_DEPTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int BOX_SIZE    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_en,
    input  logic [1:0]             pattern_sel,
    input  logic                   pause,
    output logic                   vs_no,
    output logic                   hs_no,
    output logic                   blank_no,
    output logic [PIXEL_DEPTH-1:0] outputLUM,
    output logic                   frame_done,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END  = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END  = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] BAR_W   = 16'(H_ACTIVE / 8);
    localparam logic [15:0] BOX_W   = 16'(BOX_SIZE);
    localparam logic [15:0] BOX_Y   = 16'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [15:0] BOX_MAX = 16'(H_ACTIVE - BOX_SIZE);

    typedef enum logic {
        RUN,
        HOLD
    } state_t;

    state_t      state;
    logic [15:0] hc;
    logic [15:0] vc;
    logic [15:0] box_x;
    logic [1:0]  pattern_q;

    logic                   emit;
    logic                   frame_start;
    logic                   frame_last;
    logic [1:0]             pat_eff;
    logic                   active;
    logic                   hsync_on;
    logic                   vsync_on;
    logic [PIXEL_DEPTH-1:0] lum_pat;

    // Decode the pixel at (hc,vc); the first pixel of a frame already uses
    // the pattern being latched on the same strobe.
    always_comb begin
        emit        = (state == RUN) || !pause;
        frame_start = (hc == '0) && (vc == '0);
        frame_last  = (hc == H_LAST) && (vc == V_LAST);
        pat_eff     = frame_start ? pattern_sel : pattern_q;
        active      = (hc < H_ACT) && (vc < V_ACT);
        hsync_on    = (hc >= HS_BEG) && (hc < HS_END);
        vsync_on    = (vc >= VS_BEG) && (vc < VS_END);
        lum_pat     = '0;
        case (pat_eff)
            2'd0: lum_pat = PIXEL_DEPTH'(hc[7:0]);
            2'd1: lum_pat = (((hc / BAR_W) % 16'd2) != 16'd0) ? '1 : '0;
            2'd2: lum_pat = (hc[5] ^ vc[5]) ? '1 : '0;
            default: lum_pat = ((hc >= box_x) && (hc < box_x + BOX_W) &&
                                (vc >= BOX_Y) && (vc < BOX_Y + BOX_W)) ? '1 : '0;
        endcase
    end

    // Raster counters, RUN/HOLD state machine and registered video outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            hc          <= '0;
            vc          <= '0;
            pattern_q   <= '0;
            box_x       <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            vs_no       <= 1'b1;
            hs_no       <= 1'b1;
            blank_no    <= 1'b0;
            outputLUM   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en) begin
                if (emit) begin
                    // HOLD with pause released falls through here at (0,0),
                    // so the release strobe emits the first pixel directly.
                    hs_no     <= !hsync_on;
                    vs_no     <= !vsync_on;
                    blank_no  <= active;
                    outputLUM <= active ? lum_pat : '0;
                    if (frame_start) begin
                        pattern_q <= pattern_sel;
                    end
                    if (frame_last) begin
                        hc          <= '0;
                        vc          <= '0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        box_x       <= (box_x >= BOX_MAX) ? '0 : box_x + 16'd1;
                        state       <= pause ? HOLD : RUN;
                    end else begin
                        state <= RUN;
                        if (hc == H_LAST) begin
                            hc <= '0;
                            vc <= vc + 16'd1;
                        end else begin
                            hc <= hc + 16'd1;
                        end
                    end
                end else begin
                    hs_no     <= 1'b1;
                    vs_no     <= 1'b1;
                    blank_no  <= 1'b0;
                    outputLUM <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lum_stream_gen.sv
// Directed bench for lum_stream_gen on a reduced raster:
// 64+2+3+3 = 72 clocks per line, 64+1+2+1 = 68 lines, 4896 pixels per frame.
// hs low at hc 66..68, vs low at vc 65..66, bars 8 wide, box 60x60 at y 2..61,
// box_x runs 0..4 then wraps.
module tb_lum_stream_gen;

    localparam int HT = 72;
    localparam int VT = 68;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       vs_no, hs_no, blank_no, frame_done;
    logic [7:0] outputLUM;
    logic [15:0] frame_count;

    lum_stream_gen #(
        .PIXEL_DEPTH(8),
        .H_ACTIVE(64), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(64), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .BOX_SIZE(60)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pattern_sel(pattern_sel),
        .pause(pause), .vs_no(vs_no), .hs_no(hs_no), .blank_no(blank_no),
        .outputLUM(outputLUM), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference raster position (next pixel), latched pattern, box, frame count
    int m_hc, m_vc, m_pat, m_box, m_cnt;
    bit m_hold;
    logic [10:0] m_out;
    int last_h, last_v;
    int fd_seen, hs_low_n, vs_low_n, blank_hi_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // expected {vs_no, hs_no, blank_no, lum} for one pixel of the reduced raster
    function automatic logic [10:0] pix(input int h, input int v, input int p, input int bx);
        logic vs, hs, bl;
        logic [7:0] l;
        vs = !(v == 65 || v == 66);
        hs = !(h >= 66 && h <= 68);
        bl = (h < 64) && (v < 64);
        case (p)
            0: l = 8'(h % 256);
            1: l = (((h / 8) % 2) == 1) ? 8'hFF : 8'h00;
            2: l = ((((h >> 5) ^ (v >> 5)) & 1) == 1) ? 8'hFF : 8'h00;
            default: l = (h >= bx && h < bx + 60 && v >= 2 && v < 62) ? 8'hFF : 8'h00;
        endcase
        if (!bl) l = 8'h00;
        return {vs, hs, bl, l};
    endfunction

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_pat = 0; m_box = 0; m_cnt = 0; m_hold = 0;
        m_out = 11'h600;
        last_h = -1; last_v = -1;
    endtask

    // one clock with pix_en=en; checks every output against the reference
    task automatic strobe(input bit en);
        logic [10:0] exp_o;
        bit exp_fd;
        exp_fd = 1'b0;
        exp_o = m_out;
        pix_en = en;
        if (en) begin
            if (m_hold && pause) begin
                exp_o = 11'h600;
                last_h = -1; last_v = -1;
            end else begin
                m_hold = 0;
                if (m_hc == 0 && m_vc == 0) m_pat = int'(pattern_sel);
                exp_o = pix(m_hc, m_vc, m_pat, m_box);
                last_h = m_hc; last_v = m_vc;
                if (m_hc == HT - 1 && m_vc == VT - 1) begin
                    exp_fd = 1'b1;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_box = (m_box == 4) ? 0 : m_box + 1;
                    m_hold = pause;
                    m_hc = 0; m_vc = 0;
                end else if (m_hc == HT - 1) begin
                    m_hc = 0; m_vc++;
                end else begin
                    m_hc++;
                end
            end
        end
        m_out = exp_o;
        @(posedge clk); #1;
        check_eq("stream", {vs_no, hs_no, blank_no, outputLUM}, exp_o);
        check_eq("frame_done", frame_done, exp_fd);
        check_eq("frame_count", frame_count, m_cnt);
        if (frame_done) fd_seen++;
        if (en && !hs_no) hs_low_n++;
        if (en && !vs_no) vs_low_n++;
        if (en && blank_no) blank_hi_n++;
    endtask

    // strobe every 'period' clocks until pixel (h,v) has just been emitted
    task automatic emit_to(input int h, input int v, input int period);
        bit hit;
        hit = 0;
        for (int n = 0; n < 2 * HT * VT && !hit; n++) begin
            for (int k = 1; k < period; k++) strobe(1'b0);
            strobe(1'b1);
            hit = (last_h == h && last_v == v);
        end
        check_eq("reach_pixel", hit, 1);
    endtask

    task automatic clear_counts();
        fd_seen = 0; hs_low_n = 0; vs_low_n = 0; blank_hi_n = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pix_en = 1'b1; pause = 1'b1; pattern_sel = 2'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_video", {vs_no, hs_no, blank_no, outputLUM}, 11'h600);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_frame_count", frame_count, 0);
        rst_n = 1'b1; pix_en = 1'b0; pause = 1'b0; pattern_sel = 2'd0;
        model_reset();
    endtask

    initial begin
        model_reset();
        clear_counts();
        do_reset();

        // continuous strobes, ramp pattern
        strobe(1'b1);
        check_eq("c1_first_blank", blank_no, 1);
        check_eq("c1_first_lum", outputLUM, 0);
        emit_to(37, 0, 1);
        check_eq("c1_ramp37", outputLUM, 8'h25);
        emit_to(67, 0, 1);
        check_eq("c1_hs_low", hs_no, 0);
        emit_to(69, 0, 1);
        check_eq("c1_hs_high", hs_no, 1);
        emit_to(HT - 1, VT - 1, 1);
        check_eq("c1_blank_clks", blank_hi_n, 4096);
        check_eq("c1_hs_clks", hs_low_n, 204);
        check_eq("c1_vs_clks", vs_low_n, 144);
        check_eq("c1_fd_pulses", fd_seen, 1);
        check_eq("c1_fcount", frame_count, 1);

        // strobe every 3rd clock: same sequence, held between strobes
        clear_counts();
        emit_to(HT - 1, VT - 1, 3);
        check_eq("c2_blank_strobes", blank_hi_n, 4096);
        check_eq("c2_hs_strobes", hs_low_n, 204);
        check_eq("c2_vs_strobes", vs_low_n, 144);
        check_eq("c2_fd_pulses", fd_seen, 1);
        check_eq("c2_fcount", frame_count, 2);

        // mid-frame pattern change takes effect on the next frame only
        emit_to(0, 10, 1);
        pattern_sel = 2'd2;
        emit_to(33, 10, 1);
        check_eq("c3_still_ramp", outputLUM, 8'h21);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(32, 0, 1);
        check_eq("c3_chk_32_0", outputLUM, 8'hFF);
        emit_to(0, 32, 1);
        check_eq("c3_chk_0_32", outputLUM, 8'hFF);
        emit_to(32, 32, 1);
        check_eq("c3_chk_32_32", outputLUM, 8'h00);
        emit_to(HT - 1, VT - 1, 1);
        check_eq("c3_fcount", frame_count, 4);

        // moving box from a fresh reset: box_x 0,1,2,3,4,0
        do_reset();
        clear_counts();
        pattern_sel = 2'd3;
        emit_to(0, 2, 1);  check_eq("c4_f0_left", outputLUM, 8'hFF);
        emit_to(59, 2, 1); check_eq("c4_f0_right", outputLUM, 8'hFF);
        emit_to(60, 2, 1); check_eq("c4_f0_past", outputLUM, 8'h00);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(2, 1, 1);  check_eq("c4_f2_above", outputLUM, 8'h00);
        emit_to(1, 2, 1);  check_eq("c4_f2_before", outputLUM, 8'h00);
        emit_to(2, 2, 1);  check_eq("c4_f2_left", outputLUM, 8'hFF);
        emit_to(61, 2, 1); check_eq("c4_f2_right", outputLUM, 8'hFF);
        emit_to(62, 2, 1); check_eq("c4_f2_past", outputLUM, 8'h00);
        emit_to(2, 61, 1); check_eq("c4_f2_bottom", outputLUM, 8'hFF);
        emit_to(2, 62, 1); check_eq("c4_f2_below", outputLUM, 8'h00);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(3, 2, 1);  check_eq("c4_f4_before", outputLUM, 8'h00);
        emit_to(60, 2, 1); check_eq("c4_f4_inside", outputLUM, 8'hFF);
        emit_to(HT - 1, VT - 1, 1);
        emit_to(0, 2, 1);  check_eq("c4_f5_wrap_left", outputLUM, 8'hFF);
        emit_to(60, 2, 1); check_eq("c4_f5_wrap_past", outputLUM, 8'h00);
        emit_to(HT - 1, VT - 1, 1);
        check_eq("c4_fd_pulses", fd_seen, 6);
        check_eq("c4_fcount", frame_count, 6);

        // pause mid-frame: frame completes, then idle until released
        pattern_sel = 2'd0;
        emit_to(20, 30, 1);
        pause = 1'b1;
        emit_to(5, 40, 1);
        check_eq("c5_still_running", outputLUM, 8'h05);
        emit_to(HT - 1, VT - 1, 1);
        check_eq("c5_fd", frame_done, 1);
        check_eq("c5_fcount", frame_count, 7);
        strobe(1'b1);
        check_eq("c5_idle", {vs_no, hs_no, blank_no, outputLUM}, 11'h600);
        check_eq("c5_idle_fd", frame_done, 0);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        check_eq("c5_idle_fcount", frame_count, 7);
        pause = 1'b0;
        strobe(1'b1);
        check_eq("c5_resume_blank", blank_no, 1);
        check_eq("c5_resume_lum", outputLUM, 8'h00);
        strobe(1'b1);
        check_eq("c5_resume_next", outputLUM, 8'h01);

        // reset in the middle of a frame
        emit_to(30, 20, 1);
        check_eq("c6_before", outputLUM, 8'h1E);
        rst_n = 1'b0; pix_en = 1'b1;
        @(posedge clk); #1;
        check_eq("c6_rst_video", {vs_no, hs_no, blank_no, outputLUM}, 11'h600);
        check_eq("c6_rst_fd", frame_done, 0);
        check_eq("c6_rst_fcount", frame_count, 0);
        @(posedge clk); #1;
        check_eq("c6_rst_fd2", frame_done, 0);
        rst_n = 1'b1; pix_en = 1'b0;
        model_reset();
        strobe(1'b1);
        check_eq("c6_restart_blank", blank_no, 1);
        check_eq("c6_restart_lum", outputLUM, 8'h00);
        strobe(1'b1);
        check_eq("c6_restart_next", outputLUM, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
